// File: rtl/led_pkg.sv
// Shared encodings for the board LED driver: command modes, control FSM states
// and breathe ramp direction.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock down to a single-cycle tick every DIV clocks; shared by
// the slow-rate pattern blocks.
module tick_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk50m,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = wrap;

endmodule

// File: rtl/led_pwm_driver.sv
// Board LED output stage: valid/ready mode+brightness commands, PWM dimming and
// blink/breathe patterns. Define LED_GAMMA_EN to add a squared gamma curve.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1000,
  parameter int PWM_BITS    = 8,
  parameter int BLINK_TICKS = 168
) (
  input  logic                clk50m,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PWM_BITS-1:0] cmd_level,
  output logic                led
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [PWM_BITS-1:0] ONE        = PWM_BITS'(1);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_div_check
    $error("led_pwm_driver: CLK_HZ/TICK_HZ must divide exactly and be >= 2");
  end

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  mode_e               mode_q, mode_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] bri_q, bri_d;
  dir_e                dir_q, dir_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                led_q, led_d;

  logic                tick;
  logic                accept;
  logic [PWM_BITS-1:0] target_lin;
  logic [PWM_BITS-1:0] duty_src;

  tick_prescaler #(
    .DIV (DIV)
  ) u_tick (
    .clk50m (clk50m),
    .rst    (rst),
    .tick   (tick)
  );

  assign accept = cmd_valid && ready_q;

  // Command FSM; ready is registered so it stays low throughout reset.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    level_d = level_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          state_d = ST_APPLY;
          mode_d  = mode_e'(cmd_mode);
          level_d = cmd_level;
        end
      end
      ST_APPLY: begin
        state_d = ST_RUN;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Pattern generators run in every mode; APPLY restarts them and swallows a
  // coincident tick.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    bri_d         = bri_q;
    dir_d         = dir_q;
    if (state_q == ST_APPLY) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
      bri_d         = '0;
      dir_d         = DIR_UP;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end

      if (dir_q == DIR_UP) begin
        if (bri_q < level_q) begin
          bri_d = bri_q + ONE;
        end else begin
          dir_d = DIR_DOWN;
          if (bri_q != '0) bri_d = bri_q - ONE;
        end
      end else begin
        if (bri_q != '0) begin
          bri_d = bri_q - ONE;
        end else begin
          dir_d = DIR_UP;
          if (level_q != '0) bri_d = bri_q + ONE;
        end
      end
    end
  end

  always_comb begin
    target_lin = '0;
    unique case (mode_q)
      MODE_OFF:     target_lin = '0;
      MODE_SOLID:   target_lin = level_q;
      MODE_BLINK:   target_lin = blink_phase_q ? level_q : '0;
      MODE_BREATHE: target_lin = bri_q;
    endcase
  end

`ifdef LED_GAMMA_EN
  // Squared response; full scale lands one below all-ones so it still PWMs.
  function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] t);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, t} * {{PWM_BITS{1'b0}}, t};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

  logic [PWM_BITS-1:0] target_g_q, target_g_d;

  always_comb begin
    target_g_d = gamma(target_lin);
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      target_g_q <= '0;
    end else begin
      target_g_q <= target_g_d;
    end
  end

  assign duty_src = target_g_q;
`else
  assign duty_src = target_lin;
`endif

  // Duty only changes at the last count of a PWM period so no period is torn.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + ONE;
    duty_d    = (pwm_cnt_q == PWM_MAX) ? duty_src : duty_q;
    led_d     = (duty_q == PWM_MAX) ? 1'b1 : (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      ready_q       <= 1'b0;
      mode_q        <= MODE_OFF;
      level_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      bri_q         <= '0;
      dir_q         <= DIR_UP;
      pwm_cnt_q     <= '0;
      duty_q        <= '0;
      led_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      mode_q        <= mode_d;
      level_q       <= level_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      bri_q         <= bri_d;
      dir_q         <= dir_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      led_q         <= led_d;
    end
  end

  assign cmd_ready = ready_q;
  assign led       = led_q;

endmodule
